bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised N-master bus arbiter with round-robin fairness and serial slave-address capture.
- Sits between the master ports and the master/slave select muxes of the system bus.
- Grants one master at a time, then captures a start bit plus SLAVE_ADDR_W address bits from the granted master's serial slave_select line.
- Holds the bus until that master drops its request.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- SLAVE_ADDR_W, 3, width of the serial slave address.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  system reset.
- m_request  in  NUM_MASTERS  per-master request; level, held high for the whole transaction.
- slave_select  in  1  serial select from the granted master: start bit 1, then address LSB first.
- m_grant  out  NUM_MASTERS  one-hot grant.
- bus_grant  out  $clog2(NUM_MASTERS)+1  encoded grant to the master mux; 0 = none, i+1 = master i.
- slave_grant  out  SLAVE_ADDR_W  captured slave address to the slave mux.
- slave_valid  out  1  slave_grant stable and valid.
- busy  out  1  high whenever the arbiter is not IDLE.
- timeout  out  1  one-cycle pulse on watchdog release (tied 0 without the macro).

Behaviour:
- reset is asynchronous, active-high; clock is clk. All state is in one clocked process.
- Reset values: state=IDLE, m_grant=0, bus_grant=0, slave_grant=0, slave_valid=0, busy=0, timeout=0, rr pointer=0 (master 0 highest priority first).
- All outputs are registered.
- States: IDLE, GRANT, ADDR, ACTIVE.
- IDLE:
  - Any m_request bit high at a clk edge picks a winner, searching from index ptr upward with wrap.
  - On that same edge: state=GRANT, m_grant/bus_grant set, busy=1, ptr=(winner+1) mod NUM_MASTERS.
  - Latency from request to grant is one edge.
- GRANT:
  - slave_select=1 → ADDR, bit counter=0.
  - Granted request low → IDLE, grants cleared (abandon).
  - slave_select=0 with request still high → stay.
- ADDR:
  - Each edge shifts slave_select into slave_grant[cnt], LSB first, and increments cnt.
  - After bit SLAVE_ADDR_W-1: state=ACTIVE, slave_valid=1.
  - Granted request low mid-address → IDLE, slave_grant cleared, slave_valid=0.
- ACTIVE:
  - Grant and slave_grant hold.
  - Granted request low → IDLE, all outputs cleared on that edge.
  - Other masters' requests are ignored; no preemption.
- Re-arbitration: at least one IDLE cycle between transactions (release edge, then arbitration edge).
- Simultaneous requests resolve strictly by rr pointer order. The pointer advances only on a grant.
- Requests from non-granted masters never affect GRANT, ADDR or ACTIVE.
- slave_select is ignored in IDLE and ACTIVE.
- Reset mid-transaction: immediate return to reset values, including the pointer.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Watchdog counter runs in GRANT and ADDR and resets on every state change.
  - Reaching TIMEOUT_CYCLES → IDLE, grants/slave_grant cleared, timeout pulses high for one cycle.
  - The timed-out master keeps its rr position (already advanced past it).
- Undefined:
  - No counter logic; timeout is constant 0.
  - GRANT/ADDR wait indefinitely.

Decomposition:
- Package bus_arb_pkg: state encoding typedef (IDLE=0, GRANT=1, ADDR=2, ACTIVE=3) and the bus_grant "none" constant 0.
- Sub-module rr_picker (combinational): inputs request vector and pointer; outputs one-hot winner, winner index and any_req. Instantiated once.

Test Plan:
- Reset, then m_request=4'b0010 → grant one edge later: m_grant=0010, bus_grant=2, busy=1. Then slave_select 1,1,0,1 on successive edges → slave_grant=3'b101 (bits 1,0,1 LSB first), slave_valid=1. Drop request → all outputs 0 next edge.
- All four requesting continuously, each finishing its transaction → grant order 0,1,2,3,0, with exactly one IDLE cycle between grants.
- Master 0 granted and ACTIVE, master 3 raises request → no change until master 0 releases; master 3 is granted next.
- Granted master drops request after 1 address bit → IDLE next edge, slave_grant=0, slave_valid=0, pointer advanced.
- reset asserted mid-ADDR (asynchronous, between edges) → outputs 0 immediately. After release, m_request=4'b1111 → master 0 granted.
- With ARB_TIMEOUT_EN: grant master 2, slave_select held 0 for 16 cycles → timeout pulse, m_grant=0. Next grant goes to master 3 if it is requesting. Without the macro, the same stimulus holds the grant.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding and the
// encoded "no master" value driven on bus_grant.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ADDR   = 2'd2,
    ACTIVE = 2'd3
  } arb_state_e;

  // bus_grant value meaning "no master selected"; master i is encoded as i+1.
  localparam int unsigned BUS_GRANT_NONE = 0;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: starting at index ptr and wrapping, the first
// requesting master wins. Purely combinational.
module rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] winner_oh,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   any_req
);

  int               idx;
  logic [IDX_W-1:0] sel;

  // Scan ptr, ptr+1, ... with wrap and keep the first requester found.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    idx        = 0;
    sel        = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      sel = IDX_W'(idx);
      if (!any_req && req[sel]) begin
        any_req        = 1'b1;
        winner_oh[sel] = 1'b1;
        winner_idx     = sel;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin bus arbiter with serial slave-address capture.
// A granted master sends a start bit followed by SLAVE_ADDR_W address bits
// (LSB first) on slave_select; the bus is held until its request drops.
// Optional watchdog: define ARB_TIMEOUT_EN to release a master that stalls
// in GRANT or ADDR for TIMEOUT_CYCLES cycles (pulsing timeout).
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int SLAVE_ADDR_W   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_request,
  input  logic                          slave_select,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic [$clog2(NUM_MASTERS):0]  bus_grant,
  output logic [SLAVE_ADDR_W-1:0]       slave_grant,
  output logic                          slave_valid,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int BG_W  = IDX_W + 1;
  localparam int CNT_W = (SLAVE_ADDR_W > 1) ? $clog2(SLAVE_ADDR_W) : 1;

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]  m_grant_q, m_grant_d;
  logic [BG_W-1:0]         bus_grant_q, bus_grant_d;
  logic [SLAVE_ADDR_W-1:0] slave_grant_q, slave_grant_d;
  logic                    slave_valid_q, slave_valid_d;
  logic                    busy_q, busy_d;
  logic                    release_txn;

  logic [NUM_MASTERS-1:0]  win_oh;
  logic [IDX_W-1:0]        win_idx;
  logic                    any_req;
  logic                    gnt_req;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req        (m_request),
    .ptr        (ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any_req    (any_req)
  );

  // Only the granted master's request matters once the bus is owned.
  assign gnt_req = m_request[gidx_q];

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    cnt_d         = cnt_q;
    m_grant_d     = m_grant_q;
    bus_grant_d   = bus_grant_q;
    slave_grant_d = slave_grant_q;
    slave_valid_d = slave_valid_q;
    busy_d        = busy_q;
    release_txn   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timeout_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gidx_d      = win_idx;
          m_grant_d   = win_oh;
          bus_grant_d = BG_W'(win_idx) + BG_W'(1);
          busy_d      = 1'b1;
          // Winner moves to lowest priority for the next arbitration.
          ptr_d       = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      GRANT: begin
        if (!gnt_req) begin
          release_txn = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          release_txn = 1'b1;
          timeout_d   = 1'b1;
        end
`endif
        else if (slave_select) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        if (!gnt_req) begin
          release_txn = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          release_txn = 1'b1;
          timeout_d   = 1'b1;
        end
`endif
        else begin
          slave_grant_d[cnt_q] = slave_select;
          cnt_d                = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SLAVE_ADDR_W - 1)) begin
            state_d       = ACTIVE;
            slave_valid_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!gnt_req) begin
          release_txn = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any release (done, abandon or watchdog) returns every bus output to idle.
    if (release_txn) begin
      state_d       = IDLE;
      cnt_d         = '0;
      m_grant_d     = '0;
      bus_grant_d   = BG_W'(BUS_GRANT_NONE);
      slave_grant_d = '0;
      slave_valid_d = 1'b0;
      busy_d        = 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counts cycles spent in GRANT/ADDR and restarts on every state change.
  always_comb begin
    if ((state_d != state_q) || !((state_q == GRANT) || (state_q == ADDR))) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end
`endif

  // All arbiter state, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gidx_q        <= '0;
      cnt_q         <= '0;
      m_grant_q     <= '0;
      bus_grant_q   <= BG_W'(BUS_GRANT_NONE);
      slave_grant_q <= '0;
      slave_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      cnt_q         <= cnt_d;
      m_grant_q     <= m_grant_d;
      bus_grant_q   <= bus_grant_d;
      slave_grant_q <= slave_grant_d;
      slave_valid_q <= slave_valid_d;
      busy_q        <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign m_grant     = m_grant_q;
  assign bus_grant   = bus_grant_q;
  assign slave_grant = slave_grant_q;
  assign slave_valid = slave_valid_q;
  assign busy        = busy_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // Watchdog compiled out: no legal limit can ever fire, so this is constant 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: the stimulus side predicts grant order
// and transaction timing from the round-robin rules and queues it; a monitor
// compares every cycle of DUT output against the queued expectations.
`timescale 1ns/1ps
module tb_bus_arbiter_rr;

  localparam int N    = 4;
  localparam int W    = 3;
  localparam int TO   = 16;
  localparam int BG_W = $clog2(N) + 1;

  localparam int K_DONE     = 0;
  localparam int K_ABN_GNT  = 1;
  localparam int K_ABN_ADDR = 2;
  localparam int K_TIMEOUT  = 3;

  typedef struct {
    int           idx;
    logic [W-1:0] addr;
    int           kind;
    int           valid_at;
    int           end_at;
  } txn_t;

  typedef struct {
    logic [W-1:0] addr;
    int           d;
    int           kind;
    int           nb;
    int           act;
  } plan_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    m_request = '0;
  logic            slave_select = 1'b0;
  logic [N-1:0]    m_grant;
  logic [BG_W-1:0] bus_grant;
  logic [W-1:0]    slave_grant;
  logic            slave_valid;
  logic            busy;
  logic            timeout;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .NUM_MASTERS    (N),
    .SLAVE_ADDR_W   (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_request    (m_request),
    .slave_select (slave_select),
    .m_grant      (m_grant),
    .bus_grant    (bus_grant),
    .slave_grant  (slave_grant),
    .slave_valid  (slave_valid),
    .busy         (busy),
    .timeout      (timeout)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  txn_t  exp_q[$];
  plan_t plan[N];
  int    model_ptr = 0;
  bit    fin_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   in_txn = 1'b0;
  bit   prev_pend = 1'b0;
  bit   seen_valid = 1'b0;
  int   cyc = 0;
  txn_t cur;

  always begin
    @(negedge clk or posedge reset);
    if (reset) begin
      #1;
      check("reset_m_grant", m_grant, 0);
      check("reset_bus_grant", bus_grant, 0);
      check("reset_slave_grant", slave_grant, 0);
      check("reset_slave_valid", slave_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_timeout", timeout, 0);
      in_txn = 1'b0;
      prev_pend = 1'b0;
      seen_valid = 1'b0;
    end else begin
      check("busy_vs_grant", busy, (m_grant != 0));
      if (!in_txn) begin
        check("grant_latency", (m_grant != 0), prev_pend);
        if (m_grant != 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", m_grant, 0);
          end else begin
            cur = exp_q.pop_front();
            in_txn = 1'b1;
            cyc = 0;
            seen_valid = 1'b0;
            check("grant_onehot", m_grant, 64'(1) << cur.idx);
            check("bus_grant_enc", bus_grant, cur.idx + 1);
            check("grant_addr_clear", {slave_valid, slave_grant}, 0);
          end
        end else begin
          check("idle_outputs", {bus_grant, slave_valid, slave_grant}, 0);
          check("idle_timeout", timeout, 0);
        end
      end else begin
        cyc++;
        if (m_grant != 0) begin
          check("grant_hold", m_grant, 64'(1) << cur.idx);
          check("bus_grant_hold", bus_grant, cur.idx + 1);
          check("timeout_quiet", timeout, 0);
          if (slave_valid && !seen_valid) begin
            check("valid_latency", cyc, cur.valid_at);
            check("slave_addr", slave_grant, cur.addr);
            seen_valid = 1'b1;
          end else if (seen_valid) begin
            check("slave_valid_hold", {slave_valid, slave_grant}, {1'b1, cur.addr});
          end
        end else begin
          check("release_cycle", cyc, cur.end_at);
          check("release_outputs", {bus_grant, slave_valid, slave_grant}, 0);
          check("timeout_pulse", timeout, (cur.kind == K_TIMEOUT));
          check("addr_completed", seen_valid, (cur.kind == K_DONE));
          in_txn = 1'b0;
        end
      end
      prev_pend = (m_grant == 0) && (m_request != 0);
      if (fin_req) begin
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_open_txn", in_txn, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required end of test");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic txn_t make_txn(input int w);
    txn_t t;
    t.idx  = w;
    t.addr = plan[w].addr;
    t.kind = plan[w].kind;
`ifdef ARB_TIMEOUT_EN
    if (plan[w].d >= TO) t.kind = K_TIMEOUT;
`endif
    t.valid_at = plan[w].d + 1 + W;
    case (t.kind)
      K_ABN_GNT:  t.end_at = plan[w].d + 1;
      K_ABN_ADDR: t.end_at = plan[w].d + 2 + plan[w].nb;
      K_TIMEOUT:  t.end_at = TO;
      default:    t.end_at = plan[w].d + 2 + W + plan[w].act;
    endcase
    return t;
  endfunction

  task automatic set_plan(input int i, input logic [W-1:0] addr, input int d,
                          input int kind, input int nb, input int act);
    plan[i].addr = addr;
    plan[i].d    = d;
    plan[i].kind = kind;
    plan[i].nb   = nb;
    plan[i].act  = act;
  endtask

  task automatic rand_plans();
    int r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 9);
      set_plan(i, W'($urandom), $urandom_range(0, 3),
               (r < 6) ? K_DONE : ((r < 8) ? K_ABN_GNT : K_ABN_ADDR),
               $urandom_range(0, W - 1), $urandom_range(0, 4));
    end
  endtask

  // ---------------- driver ----------------
  task automatic serve(input int g);
    plan_t pl;
    bit    gone;
    int    nbits;
    pl = plan[g];
    gone = 1'b0;
    slave_select = 1'b0;
    for (int i = 0; i < pl.d; i++) begin
      @(posedge clk); #1;
      if (m_grant == 0) begin
        gone = 1'b1;
        break;
      end
    end
    if (gone) begin
      m_request[g] = 1'b0;
      return;
    end
    if (pl.kind == K_ABN_GNT) begin
      m_request[g] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    slave_select = 1'b1;
    @(posedge clk); #1;
    nbits = (pl.kind == K_ABN_ADDR) ? pl.nb : W;
    for (int b = 0; b < nbits; b++) begin
      slave_select = pl.addr[b];
      @(posedge clk); #1;
    end
    if (pl.kind == K_ABN_ADDR) begin
      slave_select = 1'b0;
      m_request[g] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < pl.act; i++) begin
      slave_select = 1'($urandom);
      @(posedge clk); #1;
    end
    m_request[g] = 1'b0;
    slave_select = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(output bit got);
    int waitc;
    waitc = 0;
    while (m_grant == 0 && waitc < 40) begin
      slave_select = 1'($urandom);
      @(posedge clk); #1;
      waitc++;
    end
    got = (m_grant != 0);
  endtask

  // Raise mask now, and late once the first grant is seen; serve until all done.
  task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] late_in);
    logic [N-1:0] pend, late;
    int p, w, order_cnt, served, g;
    bit got;
    late = late_in & ~mask;
    pend = mask;
    p = model_ptr;
    order_cnt = 0;
    while (pend != 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(p + k) % N]) w = (p + k) % N;
      end
      exp_q.push_back(make_txn(w));
      pend[w] = 1'b0;
      p = (w + 1) % N;
      order_cnt++;
      if (order_cnt == 1) pend = pend | late;
    end
    model_ptr = p;

    m_request = m_request | mask;
    served = 0;
    while (served < order_cnt) begin
      wait_grant(got);
      if (!got) break;
      g = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (m_grant[i]) g = i;
      end
      if (served == 0) m_request = m_request | late;
      serve(g);
      served++;
    end
    m_request = '0;
    slave_select = 1'b0;
  endtask

  initial begin
    bit got;
    txn_t t;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single master 1, address bits 1,0,1 -> 3'b101.
    set_plan(1, 3'b101, 0, K_DONE, 0, 2);
    run_round(4'b0010, 4'b0000);

    // Master 2 stalls in GRANT past the watchdog limit; master 3 waits behind it.
    set_plan(2, 3'b011, TO, K_DONE, 0, 1);
    set_plan(3, 3'b110, 1, K_DONE, 0, 0);
    run_round(4'b1100, 4'b0000);

    // Everyone requesting: strict rotation 0,1,2,3.
    for (int i = 0; i < N; i++) set_plan(i, W'(i + 4), i % 2, K_DONE, 0, 1);
    run_round(4'b1111, 4'b0000);

    // Master 3 raises while master 0 owns the bus: no preemption.
    set_plan(0, 3'b111, 0, K_DONE, 0, 4);
    set_plan(3, 3'b001, 0, K_DONE, 0, 1);
    run_round(4'b0001, 4'b1000);

    // Master 1 abandons after one address bit; pointer still moves past it.
    set_plan(1, 3'b010, 0, K_ABN_ADDR, 1, 0);
    run_round(4'b0010, 4'b0000);
    set_plan(1, 3'b100, 0, K_DONE, 0, 0);
    set_plan(2, 3'b010, 2, K_DONE, 0, 0);
    run_round(4'b0110, 4'b0000);

    // Asynchronous reset in the middle of address capture.
    t.idx = 2; t.addr = '0; t.kind = K_DONE; t.valid_at = 99; t.end_at = 99;
    exp_q.push_back(t);
    m_request = 4'b0100;
    wait_grant(got);
    slave_select = 1'b1;
    @(posedge clk); #1;
    slave_select = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    m_request = '0;
    slave_select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < N; i++) set_plan(i, W'($urandom), 0, K_DONE, 0, 0);
    run_round(4'b1111, 4'b0000);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      rand_plans();
      run_round(N'($urandom_range(1, (1 << N) - 1)),
                ($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0));
    end

    repeat (2) @(posedge clk);
    fin_req = 1'b1;
  end

endmodule
